store_buffer: RTL and testbench

- Queues committed stores from the execute stage and drains them one per cycle into the data memory write port.
- Decouples store issue from memory write timing.
- Detects read-after-write hazards for loads issued while stores are still pending, and stalls those loads until the conflicting stores drain.
- Sits directly upstream of data_memory in the memory stage.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/store_buffer_byte_mask_gen.sv | 29 ++
 rtl/store_buffer.sv | 155 +++++++++++++++
 tb/tb_store_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared funct3 encodings, byte-lane constants and store-buffer entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int BYTE_LANES   = 4;
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Encoding that byte_mask_gen maps to an all-zero mask.
  localparam logic [2:0] F3_NONE = 3'b011;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [2:0]              funct3;
    logic [BYTE_LANES-1:0]   mask;
  } sb_entry_t;

  function automatic logic [2:0] load_to_store_f3(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_to_store_f3 = F3_SB;
      F3_LH, F3_LHU: load_to_store_f3 = F3_SH;
      F3_LW:         load_to_store_f3 = F3_SW;
      default:       load_to_store_f3 = F3_NONE;
    endcase
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    is_store_f3 = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_byte_mask_gen.sv
// ============================================================================
// Module  : byte_mask_gen
// Brief   : Store-width funct3 plus low address bits to 4-lane byte mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_mask_gen
  import mem_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  output logic [BYTE_LANES-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    case (i_funct3)
      F3_SB:   o_mask = 4'b0001 << i_addr_lo;
      // Half-word placement uses addr[1] only, as data_memory does.
      F3_SH:   o_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   o_mask = 4'b1111;
      default: o_mask = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module  : store_buffer
// Brief   : FIFO of committed stores draining into data_memory, with load RAW
//           hazard detection. Optional word forwarding via `STORE_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid_e,
  input  logic [ADDRESS_WIDTH-1:0] st_addr_e,
  input  logic [DATA_WIDTH-1:0]    st_data_e,
  input  logic [2:0]               st_funct3_e,
  output logic                     st_ready_e,
  input  logic                     ld_valid_e,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr_e,
  input  logic [2:0]               ld_funct3_e,
  output logic                     ld_stall,
  output logic                     ld_fwd_hit,
  output logic [DATA_WIDTH-1:0]    ld_fwd_data,
  output logic                     mem_write_m,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_m,
  output logic [DATA_WIDTH-1:0]    mem_data_m,
  output logic [2:0]               mem_funct3_m,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t             r_entries [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [BYTE_LANES-1:0] w_st_mask;
  logic [BYTE_LANES-1:0] w_ld_mask;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_conflict_any;
  sb_entry_t             w_head;

  byte_mask_gen u_st_mask (
    .i_funct3  (st_funct3_e),
    .i_addr_lo (st_addr_e[1:0]),
    .o_mask    (w_st_mask)
  );

  byte_mask_gen u_ld_mask (
    .i_funct3  (load_to_store_f3(ld_funct3_e)),
    .i_addr_lo (ld_addr_e[1:0]),
    .o_mask    (w_ld_mask)
  );

  assign w_empty    = (r_count == '0);
  assign st_ready_e = (r_count != CW'(DEPTH));
  // Unsupported widths are handshaken away without occupying an entry.
  assign w_push     = st_valid_e && st_ready_e && is_store_f3(st_funct3_e);
  assign w_pop      = !w_empty && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: r_valid and r_count gate every use of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entries[r_tail].addr   <= ENTRY_ADDR_W'(st_addr_e);
      r_entries[r_tail].data   <= ENTRY_DATA_W'(st_data_e);
      r_entries[r_tail].funct3 <= st_funct3_e;
      r_entries[r_tail].mask   <= w_st_mask;
    end
  end

  assign w_head       = r_entries[r_head];
  assign mem_write_m  = !w_empty;
  assign mem_addr_m   = ADDRESS_WIDTH'(w_head.addr);
  assign mem_data_m   = DATA_WIDTH'(w_head.data);
  assign mem_funct3_m = w_head.funct3;
  assign empty        = w_empty;
  assign count        = r_count;

`ifdef STORE_FWD_EN
  logic          w_young_full;
  logic [PW-1:0] w_young_idx;
`endif

  // Walk oldest to youngest so the last match is the youngest conflict.
  always_comb begin
    w_conflict_any = 1'b0;
`ifdef STORE_FWD_EN
    w_young_full   = 1'b0;
    w_young_idx    = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = r_head + PW'(i);
      if (r_valid[idx] &&
          (r_entries[idx].addr[ADDRESS_WIDTH-1:2] == ld_addr_e[ADDRESS_WIDTH-1:2]) &&
          ((r_entries[idx].mask & w_ld_mask) != '0)) begin
        w_conflict_any = 1'b1;
`ifdef STORE_FWD_EN
        w_young_idx    = idx;
        w_young_full   = (r_entries[idx].mask == 4'b1111);
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  logic w_fwd;
  assign w_fwd       = ld_valid_e && w_conflict_any && w_young_full;
  assign ld_fwd_hit  = w_fwd;
  assign ld_fwd_data = w_fwd ? DATA_WIDTH'(r_entries[w_young_idx].data) : '0;
  assign ld_stall    = ld_valid_e && w_conflict_any && !w_fwd;
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_stall    = ld_valid_e && w_conflict_any;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module  : tb_store_buffer
// Brief   : Directed self-checking bench for store_buffer (honours STORE_FWD_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid_e;
  logic [31:0] st_addr_e;
  logic [31:0] st_data_e;
  logic [2:0]  st_funct3_e;
  logic        st_ready_e;
  logic        ld_valid_e;
  logic [31:0] ld_addr_e;
  logic [2:0]  ld_funct3_e;
  logic        ld_stall;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        mem_write_m;
  logic [31:0] mem_addr_m;
  logic [31:0] mem_data_m;
  logic [2:0]  mem_funct3_m;
  logic        mem_ready;
  logic        empty;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid_e   (st_valid_e),
    .st_addr_e    (st_addr_e),
    .st_data_e    (st_data_e),
    .st_funct3_e  (st_funct3_e),
    .st_ready_e   (st_ready_e),
    .ld_valid_e   (ld_valid_e),
    .ld_addr_e    (ld_addr_e),
    .ld_funct3_e  (ld_funct3_e),
    .ld_stall     (ld_stall),
    .ld_fwd_hit   (ld_fwd_hit),
    .ld_fwd_data  (ld_fwd_data),
    .mem_write_m  (mem_write_m),
    .mem_addr_m   (mem_addr_m),
    .mem_data_m   (mem_data_m),
    .mem_funct3_m (mem_funct3_m),
    .mem_ready    (mem_ready),
    .empty        (empty),
    .count        (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid_e  = 1'b1;
    st_addr_e   = a;
    st_data_e   = d;
    st_funct3_e = f3;
    tick();
    st_valid_e  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    ld_valid_e  = 1'b1;
    ld_addr_e   = a;
    ld_funct3_e = f3;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    st_valid_e  = 1'b0;
    st_addr_e   = '0;
    st_data_e   = '0;
    st_funct3_e = '0;
    ld_valid_e  = 1'b0;
    ld_addr_e   = '0;
    ld_funct3_e = '0;
    mem_ready   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_mem_write", {31'd0, mem_write_m}, 32'd0);
    check("rst_st_ready",  {31'd0, st_ready_e},  32'd1);
    check("rst_empty",     {31'd0, empty},       32'd1);
    check("rst_ld_stall",  {31'd0, ld_stall},    32'd0);
    check("rst_fwd_hit",   {31'd0, ld_fwd_hit},  32'd0);
    check("rst_count",     {29'd0, count},       32'd0);

    // Single word store, 1-cycle latency to the write port
    mem_ready = 1'b1;
    store(32'h10, 32'hDEADBEEF, 3'b010);
    check("sw_write",  {31'd0, mem_write_m},  32'd1);
    check("sw_addr",   mem_addr_m,            32'h10);
    check("sw_data",   mem_data_m,            32'hDEADBEEF);
    check("sw_funct3", {29'd0, mem_funct3_m}, 32'd2);
    tick();
    check("sw_empty",  {31'd0, empty},        32'd1);
    check("sw_count",  {29'd0, count},        32'd0);

    // Fill to full with memory stalled; fifth store rejected
    mem_ready = 1'b0;
    store(32'h00, 32'hA0, 3'b010);
    store(32'h04, 32'hA1, 3'b010);
    store(32'h08, 32'hA2, 3'b010);
    check("fill_ready_3", {31'd0, st_ready_e}, 32'd1);
    store(32'h0C, 32'hA3, 3'b010);
    check("fill_ready_4", {31'd0, st_ready_e}, 32'd0);
    store(32'h20, 32'hA4, 3'b010);
    check("fill_count",   {29'd0, count},      32'd4);
    mem_ready = 1'b1;
    check("drain_0", mem_addr_m, 32'h00);
    tick();
    check("drain_1", mem_addr_m, 32'h04);
    tick();
    check("drain_2", mem_addr_m, 32'h08);
    tick();
    check("drain_3", mem_addr_m, 32'h0C);
    check("drain_3d", mem_data_m, 32'hA3);
    tick();
    check("drain_count", {29'd0, count}, 32'd0);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Byte store hazard checks
    mem_ready = 1'b0;
    store(32'h13, 32'hAA, 3'b000);
    load(32'h12, 3'b100);
    check("sb_lbu12", {31'd0, ld_stall}, 32'd0);
    load(32'h10, 3'b010);
    check("sb_lw10",  {31'd0, ld_stall}, 32'd1);
    load(32'h13, 3'b000);
    check("sb_lb13",  {31'd0, ld_stall}, 32'd1);
    load(32'h17, 3'b000);
    check("sb_lb17",  {31'd0, ld_stall}, 32'd0);
    ld_valid_e = 1'b0;
    ld_addr_e  = 32'h10;
    #1;
    check("sb_noval", {31'd0, ld_stall}, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    load(32'h10, 3'b010);
    check("sb_popped", {31'd0, ld_stall}, 32'd0);
    ld_valid_e = 1'b0;

    // Half store hazard, address bit 0 ignored
    store(32'h22, 32'hBEEF, 3'b001);
    load(32'h20, 3'b001);
    check("sh_lh20",  {31'd0, ld_stall}, 32'd0);
    load(32'h23, 3'b101);
    check("sh_lhu23", {31'd0, ld_stall}, 32'd1);
    ld_valid_e = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("sh_empty", {31'd0, empty}, 32'd1);

    // Full with push+pop: push rejected; at 3 push+pop keeps count
    mem_ready = 1'b0;
    store(32'h00, 32'hB0, 3'b010);
    store(32'h04, 32'hB1, 3'b010);
    store(32'h08, 32'hB2, 3'b010);
    store(32'h0C, 32'hB3, 3'b010);
    mem_ready   = 1'b1;
    st_valid_e  = 1'b1;
    st_addr_e   = 32'h30;
    st_data_e   = 32'hB4;
    st_funct3_e = 3'b010;
    tick();
    check("pp_full_count", {29'd0, count}, 32'd3);
    check("pp_full_head",  mem_addr_m,     32'h04);
    tick();
    st_valid_e = 1'b0;
    check("pp_3_count", {29'd0, count}, 32'd3);
    check("pp_3_head",  mem_addr_m,     32'h08);
    tick();
    check("pp_q1", mem_addr_m, 32'h0C);
    tick();
    check("pp_q2", mem_addr_m, 32'h30);
    check("pp_q2d", mem_data_m, 32'hB4);
    tick();
    check("pp_empty", {31'd0, empty}, 32'd1);

    // Unsupported funct3 is accepted but dropped
    mem_ready = 1'b0;
    check("bad_ready", {31'd0, st_ready_e}, 32'd1);
    store(32'h50, 32'h55, 3'b011);
    check("bad_count", {29'd0, count}, 32'd0);

    // Reset with pending entries
    store(32'h60, 32'hC0, 3'b010);
    store(32'h64, 32'hC1, 3'b010);
    store(32'h68, 32'hC2, 3'b010);
    check("prerst_count", {29'd0, count}, 32'd3);
    mem_ready = 1'b1;
    do_reset();
    check("midrst_empty", {31'd0, empty},       32'd1);
    check("midrst_write", {31'd0, mem_write_m}, 32'd0);
    check("midrst_count", {29'd0, count},       32'd0);
    tick();
    check("midrst_still", {31'd0, mem_write_m}, 32'd0);

    // Forwarding scenarios
    mem_ready = 1'b0;
    store(32'h40, 32'h12345678, 3'b010);
    load(32'h40, 3'b010);
`ifdef STORE_FWD_EN
    check("fwd_hit",   {31'd0, ld_fwd_hit}, 32'd1);
    check("fwd_data",  ld_fwd_data,         32'h12345678);
    check("fwd_stall", {31'd0, ld_stall},   32'd0);
`else
    check("nofwd_hit",   {31'd0, ld_fwd_hit}, 32'd0);
    check("nofwd_data",  ld_fwd_data,         32'h0);
    check("nofwd_stall", {31'd0, ld_stall},   32'd1);
`endif
    ld_valid_e = 1'b0;
    #1;
    check("fwd_noval", {31'd0, ld_fwd_hit}, 32'd0);
    store(32'h40, 32'h99, 3'b000);
    load(32'h40, 3'b010);
    check("fwd_sb_stall", {31'd0, ld_stall},   32'd1);
    check("fwd_sb_hit",   {31'd0, ld_fwd_hit}, 32'd0);
    ld_valid_e = 1'b0;
    do_reset();

    // Younger full word shadows an older byte store
    store(32'h44, 32'h77, 3'b000);
    store(32'h44, 32'hCAFEF00D, 3'b010);
    load(32'h45, 3'b100);
`ifdef STORE_FWD_EN
    check("young_hit",  {31'd0, ld_fwd_hit}, 32'd1);
    check("young_data", ld_fwd_data,         32'hCAFEF00D);
`else
    check("young_stall", {31'd0, ld_stall},  32'd1);
`endif
    ld_valid_e = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
